// File: rtl/pmem_burst_adapter.sv
// Turns line-wide read/write requests into single beat bursts on a narrow memory bus,
// reassembling read beats into a registered line. One transaction in flight at a time.
module pmem_burst_adapter #(
   parameter int LINE_WIDTH = 128,
   parameter int BEAT_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  line_read,
   input  logic                  line_write,
   input  logic [ADDR_WIDTH-1:0] line_address,
   input  logic [LINE_WIDTH-1:0] line_wdata,
   output logic                  line_resp,
   output logic [LINE_WIDTH-1:0] line_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   output logic                  mem_wvalid,
   output logic [BEAT_WIDTH-1:0] mem_wdata,
   input  logic                  mem_wready,
   input  logic                  mem_rvalid,
   input  logic [BEAT_WIDTH-1:0] mem_rdata
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_WIDTH / 8);
   localparam int LSB_W = $clog2(LINE_WIDTH);

   typedef enum logic [2:0] {IDLE, REQ, WBURST, RBURST, RESP} state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  latch;
   logic                  cnt_inc;
   logic                  rd_capture;
   logic                  last_beat;
   logic [LSB_W-1:0]      beat_lsb;

   assign last_beat = (cnt == CNT_W'(BEATS - 1));
   assign beat_lsb  = LSB_W'(cnt) << $clog2(BEAT_WIDTH);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wvalid = 1'b0;
      mem_wdata  = '0;
      line_resp  = 1'b0;
      latch      = 1'b0;
      cnt_inc    = 1'b0;
      rd_capture = 1'b0;
      case (state)
         IDLE: begin
            if (line_write || line_read) begin
               latch      = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = addr_q;
            if (mem_ack) state_next = we_q ? WBURST : RBURST;
         end
         WBURST: begin
            mem_wvalid = 1'b1;
            mem_wdata  = wdata_q[beat_lsb +: BEAT_WIDTH];
            if (mem_wready) begin
               cnt_inc = 1'b1;
               if (last_beat) state_next = RESP;
            end
         end
         RBURST: begin
            if (mem_rvalid) begin
               cnt_inc    = 1'b1;
               rd_capture = 1'b1;
               if (last_beat) state_next = RESP;
            end
         end
         RESP: begin
            line_resp  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, beat counter and read line assembly; the counter wraps to 0 on the last beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         line_rdata <= '0;
      end else begin
         if (latch) begin
            addr_q  <= {line_address[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            wdata_q <= line_wdata;
            we_q    <= line_write;
            cnt     <= '0;
         end
         if (cnt_inc) cnt <= cnt + CNT_W'(1);
         if (rd_capture) line_rdata[beat_lsb +: BEAT_WIDTH] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Randomized and directed bench for pmem_burst_adapter against a transaction-level
// model: expected beats, burst address/direction, assembled read line and resp timing.
module tb_pmem_burst_adapter;

   logic         clk;
   logic         reset_n;
   logic         line_read;
   logic         line_write;
   logic [15:0]  line_address;
   logic [127:0] line_wdata;
   logic         line_resp;
   logic [127:0] line_rdata;
   logic         mem_req;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic         mem_ack;
   logic         mem_wvalid;
   logic [31:0]  mem_wdata;
   logic         mem_wready;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;

   int           total = 0;
   int           bad   = 0;
   logic [127:0] last_rd = '0;

   pmem_burst_adapter #(.LINE_WIDTH(128), .BEAT_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .line_read    (line_read),
      .line_write   (line_write),
      .line_address (line_address),
      .line_wdata   (line_wdata),
      .line_resp    (line_resp),
      .line_rdata   (line_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_wvalid   (mem_wvalid),
      .mem_wdata    (mem_wdata),
      .mem_wready   (mem_wready),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One whole transaction, driven and observed on negedges. The model knows only the
   // protocol: beats leave LSB-first, read beats land LSB-first, one resp afterwards.
   task automatic run_txn(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [127:0] wd, input int ack_dly, input bit rnd,
                          input bit directed_rd, input int stall_beat, input bit drop_mid,
                          input bit hold_after, input int exp_resp_cyc);
      logic         exp_we;
      logic [127:0] exp_line;
      logic [31:0]  exp_beats[4];
      logic [5:0]   pat;
      int           beat, cyc, ackc, stall, ri;
      bit           burst, done, seen_req;
      exp_we   = wr;
      exp_line = last_rd;
      for (int i = 0; i < 4; i++) exp_beats[i] = wd[32*i +: 32];
      pat      = 6'b101101;
      beat = 0; cyc = 0; ackc = ack_dly; stall = 0; ri = 0;
      burst = 0; done = 0; seen_req = 0;
      line_write   = wr;
      line_read    = rd;
      line_address = addr;
      line_wdata   = wd;
      tick();
      cyc = 1;
      while (!done && cyc < 300) begin
         mem_ack    = 1'b0;
         mem_wready = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (rnd && cyc > 1) begin
            line_address = 16'($urandom);
            line_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
         if (mem_req) begin
            if (!seen_req) begin
               seen_req = 1;
               chk("req_cycle", 128'(cyc), 128'(1));
               chk("mem_addr", mem_addr, {addr[15:4], 4'h0});
               chk("mem_we", mem_we, exp_we);
            end
            if (ackc == 0) mem_ack = 1'b1;
            else ackc--;
         end
         if (mem_wvalid) begin
            if (!exp_we || beat >= 4) chk("stray_wvalid", 1, 0);
            else begin
               chk("wbeat", mem_wdata, exp_beats[beat]);
               if (beat == stall_beat && stall < 2) stall++;
               else mem_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               if (mem_wready) beat++;
            end
         end
         if (!exp_we && burst && beat < 4) begin
            if (directed_rd) begin
               mem_rvalid = pat[ri];
               ri++;
            end else mem_rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_rvalid) begin
               if (directed_rd) mem_rdata = 32'hAAAA0001 + 32'(beat);
               exp_line[32*beat +: 32] = mem_rdata;
               beat++;
            end
         end else begin
            mem_rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         if (line_resp) begin
            chk("beats_at_resp", 128'(beat), 128'(4));
            if (exp_resp_cyc > 0) chk("resp_cycle", 128'(cyc), 128'(exp_resp_cyc));
            if (!hold_after) begin
               line_write = 1'b0;
               line_read  = 1'b0;
            end
            done = 1;
         end
         if (drop_mid && cyc == 3) begin
            line_write = 1'b0;
            line_read  = 1'b0;
         end
         if (mem_ack) burst = 1;
         tick();
         cyc++;
      end
      mem_ack    = 1'b0;
      mem_wready = 1'b0;
      mem_rvalid = 1'b0;
      if (!done) chk("resp_timeout", 0, 1);
      chk("resp_single", line_resp, 1'b0);
      chk("idle_no_req", mem_req, 1'b0);
      if (exp_we) chk("rdata_kept", line_rdata, last_rd);
      else        chk("rdata_line", line_rdata, exp_line);
      last_rd = exp_line;
   endtask

   initial begin
      logic [127:0] wd;
      reset_n      = 1'b0;
      line_read    = 1'b0;
      line_write   = 1'b0;
      line_address = '0;
      line_wdata   = '0;
      mem_ack      = 1'b0;
      mem_wready   = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = '0;
      tick();
      tick();
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 16'h0);
      chk("rst_wvalid", mem_wvalid, 1'b0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_resp", line_resp, 1'b0);
      chk("rst_rdata", line_rdata, 128'h0);
      reset_n = 1'b1;
      tick();

      // Directed zero-wait write, then a gapped read and a zero-wait read
      run_txn(1, 0, 16'h1234, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 0, -1, 0, 0, 6);
      run_txn(0, 1, 16'h5678, '0, 3, 0, 1, -1, 0, 0, 0);
      chk("rd_gapped_line", line_rdata, 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001);
      run_txn(0, 1, 16'h9ABF, '0, 0, 0, 0, -1, 0, 0, 6);

      // Backpressure on beat 1, then both strobes high
      run_txn(1, 0, 16'h0100, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 0, 1, 0, 0, 0);
      run_txn(1, 1, 16'h0040, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, -1, 0, 0, 0);

      // Back-to-back: strobe held through resp, then reissued with new data and dropped mid-burst
      run_txn(1, 0, 16'h0200, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, -1, 0, 1, 6);
      run_txn(1, 0, 16'h0210, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, -1, 1, 0, 6);

      // Asynchronous reset in the middle of a write burst
      wd           = {$urandom, $urandom, $urandom, $urandom};
      line_write   = 1'b1;
      line_address = 16'h2000;
      line_wdata   = wd;
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack    = 1'b0;
      mem_wready = 1'b1;
      tick();
      tick();
      chk("pre_rst_wvalid", mem_wvalid, 1'b1);
      chk("pre_rst_beat2", mem_wdata, wd[95:64]);
      reset_n = 1'b0;
      #1;
      chk("async_rst_wvalid", mem_wvalid, 1'b0);
      chk("async_rst_req", mem_req, 1'b0);
      chk("async_rst_resp", line_resp, 1'b0);
      chk("async_rst_wdata", mem_wdata, 32'h0);
      chk("async_rst_rdata", line_rdata, 128'h0);
      line_write = 1'b0;
      mem_wready = 1'b0;
      last_rd    = '0;
      tick();
      reset_n = 1'b1;
      tick();
      run_txn(1, 0, 16'h3333, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, -1, 0, 0, 6);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         logic wr_r, rd_r;
         wr_r = 1'($urandom_range(0, 1));
         rd_r = wr_r ? 1'($urandom_range(0, 1)) : 1'b1;
         run_txn(wr_r, rd_r, 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 int'($urandom_range(0, 3)), 1, 0, -1, 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
